// File: rtl/mm_arb_pkg.sv
// Shared types and sizing for the main-memory block arbiter.
package mm_arb_pkg;
  localparam int unsigned N      = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WPB    = 4;
  localparam int unsigned K_W    = $clog2(WPB);
  localparam int unsigned BLK_W  = ADDR_W - K_W;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} arb_state_t;
endpackage

// File: rtl/mm_block_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] winner
);
  always_comb begin
    winner = req;
    if (req == 2'b11) winner = last_grant ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mm_block_arbiter.sv
// Arbitrates the single-port main memory between two L2 caches, one whole block
// per grant, and returns read words tagged with their index.
module mm_block_arbiter
  import mm_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_we,
  input  logic [BLK_W-1:0]  blk_addr0,
  input  logic [BLK_W-1:0]  blk_addr1,
  input  logic [N-1:0]      wdata0,
  input  logic [N-1:0]      wdata1,
  output logic [K_W-1:0]    word_idx,
  output logic [1:0]        grant,
  output logic [1:0]        rvalid,
  output logic [K_W-1:0]    rword_idx,
  output logic [N-1:0]      rdata,
  output logic [1:0]        done,
  output logic              mm_read_req,
  output logic              mm_write_req,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [N-1:0]      mm_wdata,
  input  logic [N-1:0]      mm_rdata
);
  arb_state_t        state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              last_q, last_d;
  logic [1:0]        grant_d, done_d, win;
  logic              rd_d, wr_d;
  logic [ADDR_W-1:0] addr_d;
  logic [K_W-1:0]    widx_d;
  logic              win_we;
  logic [BLK_W-1:0]  win_blk, g_blk;

  rr_arb2 u_rr (
    .req        (req),
    .last_grant (last_q),
    .winner     (win)
  );

  assign win_we   = win[1] ? req_we[1] : req_we[0];
  assign win_blk  = win[1] ? blk_addr1 : blk_addr0;
  assign g_blk    = grant[1] ? blk_addr1 : blk_addr0;
  assign mm_wdata = grant[1] ? wdata1 : wdata0;
  assign rdata    = mm_rdata;

  // Next-state logic computes the next cycle's memory command so every output is a flop.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    last_d  = last_q;
    grant_d = grant;
    done_d  = '0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = '0;
    widx_d  = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = win;
          last_d  = win[1];
          k_d     = '0;
          addr_d  = {win_blk, K_W'(0)};
          if (win_we) begin
            state_d = WRITE;
            wr_d    = 1'b1;
          end else begin
            state_d = READ;
            rd_d    = 1'b1;
          end
        end
      end
      WRITE: begin
        k_d = k_q + K_W'(1);
        if (k_q == K_W'(WPB - 1)) begin
          state_d = DONE;
          done_d  = grant;
        end else begin
          wr_d   = 1'b1;
          addr_d = {g_blk, k_d};
          widx_d = k_d;
        end
      end
      READ: begin
        k_d = k_q + K_W'(1);
        if (k_q == K_W'(WPB - 1)) begin
          state_d = DRAIN;
        end else begin
          rd_d   = 1'b1;
          addr_d = {g_blk, k_d};
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = grant;
      end
      DONE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      k_q          <= '0;
      last_q       <= 1'b1;
      grant        <= '0;
      done         <= '0;
      mm_read_req  <= 1'b0;
      mm_write_req <= 1'b0;
      mm_addr      <= '0;
      word_idx     <= '0;
      rvalid       <= '0;
      rword_idx    <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      last_q       <= last_d;
      grant        <= grant_d;
      done         <= done_d;
      mm_read_req  <= rd_d;
      mm_write_req <= wr_d;
      mm_addr      <= addr_d;
      word_idx     <= widx_d;
      // Read return tag trails the issue by the memory's one-cycle latency.
      rvalid       <= mm_read_req ? grant : 2'b00;
      if (mm_read_req) rword_idx <= mm_addr[K_W-1:0];
    end
  end
endmodule
